// File: rtl/connect6_defs.sv
// rtl/connect6_defs.sv - shared board geometry, picker state encoding and LFSR constants
//   BOARD_SIZE/COORD_W : board edge and coordinate width
//   MAX_TRIES/TRY_W    : occupied random candidates before the row-major scan, counter width
//   LFSR_SEED/TAPS     : whitening LFSR reset value and Galois feedback mask
//   pick_state_t       : rand_move_picker state encoding
package connect6_defs;

    localparam int BOARD_SIZE = 19;
    localparam int COORD_W    = 5;
    localparam int MAX_TRIES  = 8;
    localparam int TRY_W      = 4;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1, shift-left Galois form: bits for x^6, x^5, x^4 and x^0
    localparam logic [7:0] LFSR_TAPS = 8'h71;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SAMPLE_X = 3'd1,
        ST_SAMPLE_Y = 3'd2,
        ST_QUERY    = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DONE     = 3'd5,
        ST_FAIL     = 3'd6
    } pick_state_t;

endpackage

// File: rtl/rand_lfsr8.sv
// rtl/rand_lfsr8.sv - free-running 8-bit Galois LFSR used to whiten the random counter
//   i_clk   : clock
//   i_rst   : synchronous active-high reset, loads LFSR_SEED
//   o_value : current LFSR state, advances every cycle
module rand_lfsr8
    import connect6_defs::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    output logic [7:0] o_value
);

    logic [7:0] lfsr_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[6:0], 1'b0} ^ (lfsr_q[7] ? LFSR_TAPS : 8'h00);
        end
    end

    assign o_value = lfsr_q;

endmodule

// File: rtl/rand_move_picker.sv
// rtl/rand_move_picker.sv - random opening-move picker with occupied-cell retry and row-major scan fallback
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_req                 : move request, honoured only in IDLE
//   i_rand_value          : free-running random counter
//   o_rd_en/o_rd_x/o_rd_y : board occupancy read, answered by i_rd_occupied one cycle later
//   o_move_x/o_move_y     : last chosen move, held between requests
//   o_move_valid          : one-cycle pulse with a new move
//   o_move_fail           : one-cycle pulse when every cell is occupied
//   o_busy                : high outside IDLE
//   Build option RAND_LFSR_WHITEN_EN: XOR candidates with an internal LFSR (rand_lfsr8).
module rand_move_picker
    import connect6_defs::*;
(
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req,
    input  logic [7:0]         i_rand_value,
    output logic               o_rd_en,
    output logic [COORD_W-1:0] o_rd_x,
    output logic [COORD_W-1:0] o_rd_y,
    input  logic               i_rd_occupied,
    output logic [COORD_W-1:0] o_move_x,
    output logic [COORD_W-1:0] o_move_y,
    output logic               o_move_valid,
    output logic               o_move_fail,
    output logic               o_busy
);

    localparam logic [COORD_W-1:0] LAST_COORD = COORD_W'(BOARD_SIZE - 1);
    localparam logic [TRY_W-1:0]   TRY_LIMIT  = TRY_W'(MAX_TRIES);

    pick_state_t        state_q, state_d;
    logic [COORD_W-1:0] x_q, y_q;
    logic [COORD_W-1:0] move_x_q, move_y_q;
    logic [TRY_W-1:0]   tries_q;
    logic               scan_q;

    logic [7:0]         cand_src;
    logic [COORD_W-1:0] cand;
    logic               cand_ok;
    logic [TRY_W-1:0]   tries_inc;
    logic               last_try;
    logic               at_last_cell;

`ifdef RAND_LFSR_WHITEN_EN
    logic [7:0] lfsr_value;

    rand_lfsr8 u_lfsr (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .o_value (lfsr_value)
    );

    assign cand_src = i_rand_value ^ lfsr_value;
`else
    assign cand_src = i_rand_value;
`endif

    // Out-of-range candidates are rejected rather than folded so the accepted
    // distribution stays uniform over 0..BOARD_SIZE-1.
    assign cand         = cand_src[COORD_W-1:0];
    assign cand_ok      = (cand < COORD_W'(BOARD_SIZE));
    assign tries_inc    = tries_q + TRY_W'(1);
    assign last_try     = (tries_inc == TRY_LIMIT);
    assign at_last_cell = (x_q == LAST_COORD) && (y_q == LAST_COORD);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (i_req) state_d = ST_SAMPLE_X;
            ST_SAMPLE_X: if (cand_ok) state_d = ST_SAMPLE_Y;
            ST_SAMPLE_Y: if (cand_ok) state_d = ST_QUERY;
            ST_QUERY:    state_d = ST_CHECK;
            ST_CHECK: begin
                if (!i_rd_occupied) begin
                    state_d = ST_DONE;
                end else if (!scan_q) begin
                    state_d = last_try ? ST_QUERY : ST_SAMPLE_X;
                end else begin
                    state_d = at_last_cell ? ST_FAIL : ST_QUERY;
                end
            end
            ST_DONE:     state_d = ST_IDLE;
            ST_FAIL:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Candidate, try counter and scan position. The move registers load in
    // CHECK so they are already stable while o_move_valid pulses in DONE.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            x_q      <= '0;
            y_q      <= '0;
            move_x_q <= '0;
            move_y_q <= '0;
            tries_q  <= '0;
            scan_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_SAMPLE_X: if (cand_ok) x_q <= cand;
                ST_SAMPLE_Y: if (cand_ok) y_q <= cand;
                ST_CHECK: begin
                    if (!i_rd_occupied) begin
                        move_x_q <= x_q;
                        move_y_q <= y_q;
                    end else if (!scan_q) begin
                        tries_q <= tries_inc;
                        if (last_try) begin
                            scan_q <= 1'b1;
                            x_q    <= '0;
                            y_q    <= '0;
                        end
                    end else if (x_q == LAST_COORD) begin
                        x_q <= '0;
                        if (y_q != LAST_COORD) begin
                            y_q <= y_q + COORD_W'(1);
                        end
                    end else begin
                        x_q <= x_q + COORD_W'(1);
                    end
                end
                ST_DONE, ST_FAIL: begin
                    tries_q <= '0;
                    scan_q  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_rd_en      = 1'b0;
        o_move_valid = 1'b0;
        o_move_fail  = 1'b0;
        o_busy       = (state_q != ST_IDLE);
        case (state_q)
            ST_QUERY: o_rd_en      = 1'b1;
            ST_DONE:  o_move_valid = 1'b1;
            ST_FAIL:  o_move_fail  = 1'b1;
            default: ;
        endcase
    end

    assign o_rd_x   = x_q;
    assign o_rd_y   = y_q;
    assign o_move_x = move_x_q;
    assign o_move_y = move_y_q;

endmodule

// File: tb/tb_rand_move_picker.sv
// tb/tb_rand_move_picker.sv - self-checking bench for rand_move_picker with a cycle-timeline reference model
module tb_rand_move_picker;
    import connect6_defs::*;

    localparam int MAXC = 40000;

    logic               i_clk = 1'b0;
    logic               i_rst = 1'b1;
    logic               i_req = 1'b0;
    logic [7:0]         i_rand_value = 8'd0;
    logic               i_rd_occupied = 1'b0;
    logic               o_rd_en;
    logic [COORD_W-1:0] o_rd_x, o_rd_y, o_move_x, o_move_y;
    logic               o_move_valid, o_move_fail, o_busy;

    rand_move_picker dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_req         (i_req),
        .i_rand_value  (i_rand_value),
        .o_rd_en       (o_rd_en),
        .o_rd_x        (o_rd_x),
        .o_rd_y        (o_rd_y),
        .i_rd_occupied (i_rd_occupied),
        .o_move_x      (o_move_x),
        .o_move_y      (o_move_y),
        .o_move_valid  (o_move_valid),
        .o_move_fail   (o_move_fail),
        .o_busy        (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rand_seq [MAXC];
    bit         board [BOARD_SIZE][BOARD_SIZE];

    // expected outputs per cycle
    bit e_busy [MAXC];
    bit e_rd   [MAXC];
    bit e_valid[MAXC];
    bit e_fail [MAXC];
    int e_rx [MAXC];
    int e_ry [MAXC];
    int e_mx [MAXC];
    int e_my [MAXC];
    int fill_ptr   = 1;
    int cur_mx     = 0;
    int cur_my     = 0;
    int scan_start = -1;

    int req_cyc  = -1;
    int busy_end = -1;
    int rst_cyc  = -1;

    // observations
    logic               prev_rd_en = 1'b0;
    logic [COORD_W-1:0] prev_rx = '0, prev_ry = '0;
    int rd_cnt, valid_cnt, fail_cnt, first_rd_cyc, valid_cyc;
    logic [COORD_W-1:0] first_rd_x, first_rd_y, valid_mx, valid_my;
    logic               busy_hist[MAXC];
    logic [COORD_W-1:0] mx_hist[MAXC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clear_obs();
        rd_cnt = 0; valid_cnt = 0; fail_cnt = 0; first_rd_cyc = -1; valid_cyc = -1;
        first_rd_x = '0; first_rd_y = '0; valid_mx = '0; valid_my = '0;
    endtask

    always @(negedge i_clk) begin
        if (cyc >= 1 && cyc < fill_ptr) begin
            chk("busy", o_busy, e_busy[cyc]);
            chk("rd_en", o_rd_en, e_rd[cyc]);
            if (e_rd[cyc]) begin
                chk("rd_x", o_rd_x, e_rx[cyc]);
                chk("rd_y", o_rd_y, e_ry[cyc]);
            end
            chk("move_valid", o_move_valid, e_valid[cyc]);
            chk("move_fail", o_move_fail, e_fail[cyc]);
            chk("move_x", o_move_x, e_mx[cyc]);
            chk("move_y", o_move_y, e_my[cyc]);
        end
        if (o_rd_en === 1'b1) begin
            rd_cnt++;
            if (first_rd_cyc < 0) begin
                first_rd_cyc = cyc; first_rd_x = o_rd_x; first_rd_y = o_rd_y;
            end
        end
        if (o_move_valid === 1'b1) begin
            valid_cnt++; valid_cyc = cyc; valid_mx = o_move_x; valid_my = o_move_y;
        end
        if (o_move_fail === 1'b1) fail_cnt++;
        busy_hist[cyc] = o_busy;
        mx_hist[cyc]   = o_move_x;
        prev_rd_en = o_rd_en; prev_rx = o_rd_x; prev_ry = o_rd_y;
    end

    // Inputs for cycle cyc are applied 1 time unit after the edge that starts it;
    // the board answers the read issued in the previous cycle.
    task automatic step();
        @(posedge i_clk);
        cyc++;
        #1;
        i_rst = (cyc < 3) || (cyc == rst_cyc);
        i_rand_value = rand_seq[cyc];
        i_rd_occupied = (prev_rd_en === 1'b1) ? board[prev_rx][prev_ry] : 1'($urandom);
        if (cyc == req_cyc)                         i_req = 1'b1;
        else if (cyc > req_cyc && cyc < busy_end)   i_req = 1'($urandom);
        else                                        i_req = 1'b0;
    endtask

    task automatic mark(input int c, input bit busy);
        e_busy[c] = busy; e_rd[c] = 0; e_valid[c] = 0; e_fail[c] = 0;
        e_rx[c] = 0; e_ry[c] = 0; e_mx[c] = cur_mx; e_my[c] = cur_my;
    endtask

    task automatic mark_read(input int c, input int x, input int y);
        mark(c, 1); e_rd[c] = 1; e_rx[c] = x; e_ry[c] = y;
    endtask

    // Timeline of one request raised at cycle T: returns E, the first idle cycle after.
    task automatic predict(input int T, output int E);
        int t, x, y, tries;
        bit found;
        for (int c = fill_ptr; c <= T; c++) mark(c, 0);
        t = T + 1; tries = 0; found = 0; x = 0; y = 0; scan_start = -1;
        while (!found && tries < MAX_TRIES) begin
            while (int'(rand_seq[t][4:0]) >= BOARD_SIZE) begin mark(t, 1); t++; end
            x = int'(rand_seq[t][4:0]); mark(t, 1); t++;
            while (int'(rand_seq[t][4:0]) >= BOARD_SIZE) begin mark(t, 1); t++; end
            y = int'(rand_seq[t][4:0]); mark(t, 1); t++;
            mark_read(t, x, y); t++;
            mark(t, 1); t++;
            if (!board[x][y]) found = 1; else tries++;
        end
        if (!found) begin
            scan_start = t;
            for (int yy = 0; yy < BOARD_SIZE && !found; yy++) begin
                for (int xx = 0; xx < BOARD_SIZE && !found; xx++) begin
                    mark_read(t, xx, yy); t++;
                    mark(t, 1); t++;
                    if (!board[xx][yy]) begin found = 1; x = xx; y = yy; end
                end
            end
        end
        if (found) begin
            cur_mx = x; cur_my = y;
            mark(t, 1); e_valid[t] = 1;
        end else begin
            mark(t, 1); e_fail[t] = 1;
        end
        E = t + 1;
        fill_ptr = E;
    endtask

    task automatic run_req(input int T, output int E);
        clear_obs();
        predict(T, E);
        req_cyc = T; busy_end = E;
        while (cyc < E + 1) step();
    endtask

    task automatic set_board(input int pct);
        foreach (board[i, j]) board[i][j] = ($urandom_range(99, 0) < pct);
    endtask

    initial begin
        int T, E, R, pct;
        foreach (rand_seq[i]) rand_seq[i] = 8'($urandom);
        set_board(0);

        // 1: immediate free cell (3,7)
        T = 5;
        rand_seq[T+1] = 8'd3; rand_seq[T+2] = 8'd7;
        run_req(T, E);
        chk("t1_rd_cycle", first_rd_cyc, T + 3);
        chk("t1_rd_xy", {first_rd_x, first_rd_y}, {5'd3, 5'd7});
        chk("t1_valid_cycle", valid_cyc, T + 5);
        chk("t1_move", {valid_mx, valid_my}, {5'd3, 5'd7});
        chk("t1_busy_after", busy_hist[T+6], 1'b0);

        // 2: out-of-range samples skipped
        T = cyc + 2;
        rand_seq[T+1] = 8'd25; rand_seq[T+2] = 8'd30; rand_seq[T+3] = 8'd4; rand_seq[T+4] = 8'd10;
        run_req(T, E);
        chk("t2_valid_cycle", valid_cyc, T + 7);
        chk("t2_move", {valid_mx, valid_my}, {5'd4, 5'd10});

        // 3: first candidate occupied, retry lands on (5,6)
        board[3][7] = 1;
        T = cyc + 2;
        rand_seq[T+1] = 8'd3; rand_seq[T+2] = 8'd7; rand_seq[T+5] = 8'd5; rand_seq[T+6] = 8'd6;
        run_req(T, E);
        chk("t3_reads", rd_cnt, 2);
        chk("t3_move", {valid_mx, valid_my}, {5'd5, 5'd6});

        // 4: only (2,0) free, random candidates kept away from it
        set_board(100); board[2][0] = 0;
        T = cyc + 2;
        for (int i = 1; i < 80; i++) rand_seq[T+i] = {3'($urandom), 5'($urandom_range(18, 3))};
        run_req(T, E);
        chk("t4_reads", rd_cnt, MAX_TRIES + 3);
        chk("t4_move", {valid_mx, valid_my}, {5'd2, 5'd0});

        // 5: full board
        set_board(100);
        T = cyc + 2;
        run_req(T, E);
        chk("t5_fail_pulses", fail_cnt, 1);
        chk("t5_valid_pulses", valid_cnt, 0);
        chk("t5_move_held", {o_move_x, o_move_y}, {5'd2, 5'd0});

        // 6: reset while in CHECK mid-scan, then a fresh request
        clear_obs();
        T = cyc + 2;
        predict(T, E);
        req_cyc = T; busy_end = E;
        R = scan_start + 11;
        rst_cyc = R; busy_end = R;
        while (cyc < R) step();
        cur_mx = 0; cur_my = 0; fill_ptr = R + 1;
        step();
        set_board(100); board[1][1] = 0;
        T = cyc + 2;
        rand_seq[T+1] = 8'd1; rand_seq[T+2] = 8'd1;
        run_req(T, E);
        chk("t6_idle_after_rst", busy_hist[R+1], 1'b0);
        chk("t6_move_cleared", mx_hist[R+1], 5'd0);
        chk("t6_valid_cycle", valid_cyc, T + 5);
        chk("t6_move", {valid_mx, valid_my}, {5'd1, 5'd1});

        // randomized requests over boards of varying density
        for (int n = 0; n < 24; n++) begin
            pct = $urandom_range(95, 10);
            set_board(pct);
            T = cyc + 2 + $urandom_range(3, 0);
            for (int i = 1; i < 300; i++) rand_seq[T+i] = 8'($urandom);
            run_req(T, E);
            chk("rand_one_outcome", valid_cnt + fail_cnt, 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rand_move_picker.md
Name: rand_move_picker

Overview:
Consumer of the free-running 8-bit random counter used for the opening move when the FPGA plays black. On a request from master_sm it samples the counter value, converts it into an in-range board coordinate and checks that cell against board memory. It retries on occupied cells and falls back to a deterministic row-major scan. It returns one legal move or a fail flag to master_sm.

Parameters:
BOARD_SIZE, 19, board edge length; legal coordinates are 0..BOARD_SIZE-1
COORD_W, 5, coordinate width
MAX_TRIES, 8, occupied random candidates allowed before falling back to the scan
TRY_W, 4, width of the try counter; must hold MAX_TRIES

Ports:
i_clk  input  1  clock
i_rst  input  1  synchronous, active-high reset
i_req  input  1  move request from master_sm; sampled only in IDLE
i_rand_value  input  8  random counter output
o_rd_en  output  1  board occupancy read strobe
o_rd_x  output  COORD_W  read column
o_rd_y  output  COORD_W  read row
i_rd_occupied  input  1  occupancy of the cell read; valid exactly 1 cycle after o_rd_en
o_move_x  output  COORD_W  chosen column; held until the next valid move
o_move_y  output  COORD_W  chosen row; held until the next valid move
o_move_valid  output  1  one-cycle pulse when a move is chosen
o_move_fail  output  1  one-cycle pulse when the board is full
o_busy  output  1  high in every state except IDLE

Behaviour:
- Single clock domain, i_clk. Reset is synchronous and active-high on i_rst.
- Reset: state IDLE; try count 0; every output 0, including o_move_x and o_move_y.
- States and transitions:
  - IDLE: if i_req, go to SAMPLE_X.
  - SAMPLE_X: candidate c = i_rand_value[4:0]. If c < BOARD_SIZE, latch it as x and go to SAMPLE_Y. Otherwise stay and resample next cycle.
  - SAMPLE_Y: same rule; the accepted value is latched as y, then go to QUERY.
  - QUERY: o_rd_en = 1 for exactly one cycle with o_rd_x/o_rd_y = (x, y). Go to CHECK.
  - CHECK: if i_rd_occupied = 0, go to DONE.
    - If occupied and in random mode: increment the try count. If the new count equals MAX_TRIES, set scan mode with (x, y) = (0, 0) and go to QUERY. Otherwise go to SAMPLE_X.
    - If occupied and in scan mode: advance x, wrapping x at BOARD_SIZE-1 to 0 and incrementing y. Go to QUERY. If the failing cell was (BOARD_SIZE-1, BOARD_SIZE-1), go to FAIL instead.
  - DONE: register o_move_x/o_move_y, pulse o_move_valid, clear try count and scan mode, go to IDLE.
  - FAIL: pulse o_move_fail, clear try count and scan mode, go to IDLE; o_move_x/o_move_y unchanged.
- Best-case latency: i_req high at cycle T gives o_rd_en at T+3 and o_move_valid at T+5.
- i_req outside IDLE is ignored; there is no queuing.
- o_rd_en is never asserted outside QUERY.
- Scan order is row-major, x inner; each cell costs 2 cycles (QUERY, CHECK).
- Reset in any state, including mid-scan, returns to IDLE on the next edge with no valid or fail pulse.

Optional Feature:
- Macro: RAND_LFSR_WHITEN_EN.
- When defined: an 8-bit Galois LFSR (polynomial x^8+x^6+x^5+x^4+1) is reset to 8'hA5 and advances every cycle, including in IDLE. Candidates are (i_rand_value ^ lfsr)[4:0]; the range rule is unchanged.
- When undefined: candidates are raw i_rand_value[4:0], and no LFSR flops exist.

Decomposition:
- Shared package/defines file connect6_defs holds BOARD_SIZE, COORD_W, the state encodings, and the LFSR seed and taps.
- One natural sub-module, rand_lfsr8, is instantiated only under RAND_LFSR_WHITEN_EN.
- The state machine, try counter and scan counters stay in rand_move_picker.

Test Plan:
1. Macro undefined, bench drives i_rand_value = 3 then 7, i_rd_occupied = 0, i_req at T -> o_rd_en at T+3 with (3,7); o_move_valid at T+5 with (3,7); o_busy low at T+6.
2. i_rand_value sequence 25, 30, 4, 10 -> the two out-of-range samples are skipped; move (4,10) with o_move_valid at T+7.
3. First check occupied, next samples 5 then 6 free -> o_rd_en pulses twice; final move (5,6).
4. All random candidates occupied, scan cells (0,0) and (1,0) occupied, (2,0) free -> after 8 random tries, scan reads (0,0), (1,0), (2,0); move (2,0).
5. All 361 cells occupied -> exactly one o_move_fail pulse after the scan completes; no o_move_valid; o_move_x/o_move_y keep their previous values.
6. i_rst asserted while in CHECK mid-scan -> IDLE and all outputs 0 next cycle; a following i_req with free cell (1,1) yields move (1,1) at T+5.
